// File: rtl/exe_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_stage_pkg
// Shared encodings for the execute stage of the 5-stage ARM pipeline:
//   - exe_cmd_e : ALU command codes driven from the decode stage
//   - shift_e   : register-operand shift types (shift_op[6:5])
//   - fwd_sel_e : operand forwarding selects, shared with the forwarding unit
//   - nzcv_t    : layout of the status register {N,Z,C,V}
// -----------------------------------------------------------------------------
package exe_stage_pkg;

  typedef enum logic [3:0] {
    EXE_CMD_MOV = 4'b0001,
    EXE_CMD_ADD = 4'b0010,
    EXE_CMD_ADC = 4'b0011,
    EXE_CMD_SUB = 4'b0100,  // also CMP
    EXE_CMD_SBC = 4'b0101,
    EXE_CMD_AND = 4'b0110,  // also TST
    EXE_CMD_ORR = 4'b0111,
    EXE_CMD_EOR = 4'b1000,
    EXE_CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_e;

  // Select code 2'b11 is not named: it behaves exactly like FWD_ID.
  typedef enum logic [1:0] {
    FWD_ID  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage : exe_stage_pkg

// File: rtl/exe_stage_val2_gen.sv
// -----------------------------------------------------------------------------
// exe_stage_val2_gen
// Combinational builder for the ALU second operand (Val2).
// Ports:
//   mem_en_i   : 1 = load/store, Val2 is the zero-extended 12-bit offset
//   imm_i      : 1 = Val2 is an 8-bit immediate rotated right by 2*rot
//   shift_op_i : 12-bit shifter operand field from the instruction
//   rm_i       : forwarded Rm value (register operand)
//   val2_o     : resulting operand
// -----------------------------------------------------------------------------
module exe_stage_val2_gen
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              mem_en_i,
  input  logic              imm_i,
  input  logic [11:0]       shift_op_i,
  input  logic [DATA_W-1:0] rm_i,
  output logic [DATA_W-1:0] val2_o
);

  // Rotate right; an amount of 0 yields x unchanged because a shift by
  // DATA_W or more produces all zeros.
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                            input int unsigned         n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] off_ext;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;

  assign imm_ext = {{(DATA_W-8){1'b0}}, shift_op_i[7:0]};
  assign off_ext = {{(DATA_W-12){1'b0}}, shift_op_i};
  assign shamt   = shift_op_i[11:7];

  // Every shift form is the identity for shamt == 0, so no special case.
  always_comb begin
    // NOTE: default first so every path assigns shifted and no latch is inferred.
    shifted = rm_i;
    case (shift_op_i[6:5])
      SHIFT_LSL: shifted = rm_i << shamt;
      SHIFT_LSR: shifted = rm_i >> shamt;
      SHIFT_ASR: shifted = $unsigned($signed(rm_i) >>> shamt);
      SHIFT_ROR: shifted = ror(rm_i, 32'(shamt));
      default:   shifted = rm_i;
    endcase
  end

  always_comb begin
    if (mem_en_i) begin
      val2_o = off_ext;
    end else if (imm_i) begin
      val2_o = ror(imm_ext, 32'({shift_op_i[11:8], 1'b0}));
    end else begin
      val2_o = shifted;
    end
  end

endmodule : exe_stage_val2_gen

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage ARM pipeline.
//   - Selects Rn/Rm between ID/EX, MEM-stage ALU result and WB value
//     (sel_src1/sel_src2 from the forwarding unit).
//   - Builds Val2, runs the ALU, maintains the NZCV status register.
//   - Computes the branch target combinationally.
//   - Registers the results into the EX/MEM pipeline register.
// Ports:
//   clk, rst (sync, active-high), freeze (hold EX/MEM and status)
//   ID/EX inputs : pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in,
//                  exe_cmd_in, val_rn_in, val_rm_in, imm_in, shift_op_in,
//                  simm24_in, dest_in
//   forwarding   : sel_src1, sel_src2, mem_fwd_val, wb_fwd_val
//   combinational: branch_taken, branch_addr
//   registered   : status {N,Z,C,V}, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
//                  ex_alu_res, ex_st_val, ex_dest
// -----------------------------------------------------------------------------
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_op_in,
  input  logic [23:0]       simm24_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic [DATA_W-1:0] ex_alu_res,
  output logic [DATA_W-1:0] ex_st_val,
  output logic [REG_AW-1:0] ex_dest
);

  localparam int MSB = DATA_W - 1;

  // ---------------------------------------------------------------------------
  // Branch target: PC + sign-extended word offset
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] br_off;

  assign br_off       = {{(DATA_W-26){simm24_in[23]}}, simm24_in, 2'b00};
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + br_off;

  // ---------------------------------------------------------------------------
  // Operand forwarding (2'b11 falls through to the ID/EX value)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] rm_f;

  always_comb begin
    case (sel_src1)
      FWD_MEM: op1 = mem_fwd_val;
      FWD_WB:  op1 = wb_fwd_val;
      default: op1 = val_rn_in;
    endcase
  end

  always_comb begin
    case (sel_src2)
      FWD_MEM: rm_f = mem_fwd_val;
      FWD_WB:  rm_f = wb_fwd_val;
      default: rm_f = val_rm_in;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Val2
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] val2;

  exe_stage_val2_gen #(
    .DATA_W (DATA_W)
  ) u_val2_gen (
    .mem_en_i   (mem_r_en_in | mem_w_en_in),
    .imm_i      (imm_in),
    .shift_op_i (shift_op_in),
    .rm_i       (rm_f),
    .val2_o     (val2)
  );

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  nzcv_t status_q, status_d;

  logic              cin;    // carry-in for ADC
  logic              bin;    // borrow-in for SBC
  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic [DATA_W-1:0] alu_res;
  logic              flags_we;  // command is a defined one

  // ADC/SBC consume the registered carry, never the value being computed now.
  assign cin   = (exe_cmd_in == EXE_CMD_ADC) & status_q.c;
  assign bin   = (exe_cmd_in == EXE_CMD_SBC) & ~status_q.c;
  assign add_w = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, cin};
  // Bit DATA_W of the difference is the borrow; C is its complement.
  assign sub_w = {1'b0, op1} - {1'b0, val2} - {{DATA_W{1'b0}}, bin};

  always_comb begin
    alu_res    = '0;
    flags_we   = 1'b1;
    status_d   = status_q;  // C and V are kept unless an arithmetic op sets them
    case (exe_cmd_in)
      EXE_CMD_MOV: alu_res = val2;
      EXE_CMD_MVN: alu_res = ~val2;
      EXE_CMD_AND: alu_res = op1 & val2;
      EXE_CMD_ORR: alu_res = op1 | val2;
      EXE_CMD_EOR: alu_res = op1 ^ val2;
      EXE_CMD_ADD, EXE_CMD_ADC: begin
        alu_res    = add_w[MSB:0];
        status_d.c = add_w[DATA_W];
        status_d.v = (op1[MSB] == val2[MSB]) && (add_w[MSB] != op1[MSB]);
      end
      EXE_CMD_SUB, EXE_CMD_SBC: begin
        alu_res    = sub_w[MSB:0];
        status_d.c = ~sub_w[DATA_W];
        status_d.v = (op1[MSB] != val2[MSB]) && (sub_w[MSB] != op1[MSB]);
      end
      default: flags_we = 1'b0;
    endcase
    status_d.n = alu_res[MSB];
    status_d.z = (alu_res == '0);
  end

  // ---------------------------------------------------------------------------
  // Status register: reset wins over freeze; undefined commands leave it alone
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      status_q <= '0;
    end else if (s_in && !freeze && flags_we) begin
      status_q <= status_d;
    end
  end

  assign status = status_q;

  // ---------------------------------------------------------------------------
  // EX/MEM pipeline register
  // ---------------------------------------------------------------------------
  logic              wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [DATA_W-1:0] alu_res_q, st_val_q;
  logic [REG_AW-1:0] dest_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
    end else if (!freeze) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      alu_res_q  <= alu_res;
      st_val_q   <= rm_f;
      dest_q     <= dest_in;
    end
  end

  assign ex_wb_en    = wb_en_q;
  assign ex_mem_r_en = mem_r_en_q;
  assign ex_mem_w_en = mem_w_en_q;
  assign ex_alu_res  = alu_res_q;
  assign ex_st_val   = st_val_q;
  assign ex_dest     = dest_q;

endmodule : exe_stage

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Directed, table-driven checks for exe_stage plus hand-written sequences
// for flags, freeze, reset-over-freeze and branch target.
// -----------------------------------------------------------------------------
module tb_exe_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010,
                         C_ADC = 4'b0011, C_SUB = 4'b0100, C_SBC = 4'b0101,
                         C_AND = 4'b0110, C_ORR = 4'b0111, C_EOR = 4'b1000,
                         C_BAD = 4'b1111;

  logic          clk = 1'b0;
  logic          rst, freeze;
  logic [DW-1:0] pc_in;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]    exe_cmd_in;
  logic [DW-1:0] val_rn_in, val_rm_in;
  logic          imm_in;
  logic [11:0]   shift_op_in;
  logic [23:0]   simm24_in;
  logic [AW-1:0] dest_in;
  logic [1:0]    sel_src1, sel_src2;
  logic [DW-1:0] mem_fwd_val, wb_fwd_val;
  logic          branch_taken;
  logic [DW-1:0] branch_addr;
  logic [3:0]    status;
  logic          ex_wb_en, ex_mem_r_en, ex_mem_w_en;
  logic [DW-1:0] ex_alu_res, ex_st_val;
  logic [AW-1:0] ex_dest;

  int errors = 0;
  int checks = 0;

  exe_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .pc_in        (pc_in),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .b_in         (b_in),
    .s_in         (s_in),
    .exe_cmd_in   (exe_cmd_in),
    .val_rn_in    (val_rn_in),
    .val_rm_in    (val_rm_in),
    .imm_in       (imm_in),
    .shift_op_in  (shift_op_in),
    .simm24_in    (simm24_in),
    .dest_in      (dest_in),
    .sel_src1     (sel_src1),
    .sel_src2     (sel_src2),
    .mem_fwd_val  (mem_fwd_val),
    .wb_fwd_val   (wb_fwd_val),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .status       (status),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_r_en  (ex_mem_r_en),
    .ex_mem_w_en  (ex_mem_w_en),
    .ex_alu_res   (ex_alu_res),
    .ex_st_val    (ex_st_val),
    .ex_dest      (ex_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel1, sel2;
    logic [31:0] mfwd, wfwd, rn, rm;
    logic [3:0]  cmd;
    logic        imm;
    logic [11:0] sop;
    logic        mr, mw, wb;
    logic [3:0]  dest;
    logic [31:0] exp_res, exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] sel1, logic [1:0] sel2,
                              logic [31:0] mfwd, logic [31:0] wfwd,
                              logic [31:0] rn, logic [31:0] rm, logic [3:0] cmd,
                              logic imm, logic [11:0] sop, logic mr, logic mw,
                              logic wb, logic [3:0] dest,
                              logic [31:0] exp_res, logic [31:0] exp_st);
    vec_t v;
    v.name = name; v.sel1 = sel1; v.sel2 = sel2; v.mfwd = mfwd; v.wfwd = wfwd;
    v.rn = rn; v.rm = rm; v.cmd = cmd; v.imm = imm; v.sop = sop;
    v.mr = mr; v.mw = mw; v.wb = wb; v.dest = dest;
    v.exp_res = exp_res; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic idle_inputs();
    freeze = 0; pc_in = '0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    b_in = 0; s_in = 0; exe_cmd_in = '0; val_rn_in = '0; val_rm_in = '0;
    imm_in = 0; shift_op_in = '0; simm24_in = '0; dest_in = '0;
    sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;
  endtask

  // Simple ID/EX-sourced operation, no forwarding, no memory.
  task automatic drive_op(input logic [3:0] cmd, input logic [31:0] rn,
                          input logic [31:0] rm, input logic imm,
                          input logic [11:0] sop, input logic s);
    exe_cmd_in = cmd; val_rn_in = rn; val_rm_in = rm; imm_in = imm;
    shift_op_in = sop; s_in = s; sel_src1 = 2'b00; sel_src2 = 2'b00;
    mem_r_en_in = 0; mem_w_en_in = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_res", ex_alu_res, 32'h0);
    check("rst_st_val",  ex_st_val,  32'h0);
    check("rst_status",  {28'h0, status}, 32'h0);
    check("rst_ctrl",    {29'h0, ex_wb_en, ex_mem_r_en, ex_mem_w_en}, 32'h0);
    check("rst_dest",    {28'h0, ex_dest}, 32'h0);
    @(negedge clk);
    rst = 0;

    // ---- table: s_in = 0 throughout, so C stays 0 for ADC/SBC ----
    vecs.push_back(mk("fwd_mem_add", 2'b01, 2'b00, 32'd5, 32'd0, 32'd9, 32'd0, C_ADD, 1, 12'h003, 0, 0, 1, 4'd1, 32'd8, 32'd0));
    vecs.push_back(mk("fwd_wb_add",  2'b10, 2'b00, 32'd5, 32'd7, 32'd9, 32'd0, C_ADD, 1, 12'h003, 0, 0, 1, 4'd2, 32'd10, 32'd0));
    vecs.push_back(mk("sel11_is_id", 2'b11, 2'b11, 32'd5, 32'd7, 32'd9, 32'd4, C_ADD, 1, 12'h003, 0, 0, 1, 4'd3, 32'd12, 32'd4));
    vecs.push_back(mk("imm_rot8",    2'b00, 2'b00, 0, 0, 0, 0, C_MOV, 1, 12'h4FF, 0, 0, 1, 4'd4, 32'hFF000000, 32'h0));
    vecs.push_back(mk("imm_rot2",    2'b00, 2'b00, 0, 0, 0, 0, C_MOV, 1, 12'h103, 0, 0, 1, 4'd4, 32'hC0000000, 32'h0));
    vecs.push_back(mk("asr4",        2'b00, 2'b00, 0, 0, 0, 32'h80000000, C_MOV, 0, 12'h240, 0, 0, 1, 4'd5, 32'hF8000000, 32'h80000000));
    vecs.push_back(mk("lsl1",        2'b00, 2'b00, 0, 0, 0, 32'h40000001, C_MOV, 0, 12'h080, 0, 0, 1, 4'd6, 32'h80000002, 32'h40000001));
    vecs.push_back(mk("lsr31",       2'b00, 2'b00, 0, 0, 0, 32'h80000000, C_MOV, 0, 12'hFA0, 0, 0, 1, 4'd7, 32'h1, 32'h80000000));
    vecs.push_back(mk("ror8",        2'b00, 2'b00, 0, 0, 0, 32'h12345678, C_MOV, 0, 12'h460, 0, 0, 1, 4'd8, 32'h78123456, 32'h12345678));
    vecs.push_back(mk("asr0_noshift",2'b00, 2'b00, 0, 0, 0, 32'h80000000, C_MOV, 0, 12'h040, 0, 0, 1, 4'd8, 32'h80000000, 32'h80000000));
    vecs.push_back(mk("mvn",         2'b00, 2'b00, 0, 0, 0, 32'h0, C_MVN, 0, 12'h000, 0, 0, 1, 4'd9, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(mk("sub",         2'b00, 2'b00, 0, 0, 32'd10, 32'd3, C_SUB, 0, 12'h000, 0, 0, 1, 4'd10, 32'd7, 32'd3));
    vecs.push_back(mk("and",         2'b00, 2'b00, 0, 0, 32'hF0F0, 32'hFF00, C_AND, 0, 12'h000, 0, 0, 1, 4'd11, 32'hF000, 32'hFF00));
    vecs.push_back(mk("orr",         2'b00, 2'b00, 0, 0, 32'hF0F0, 32'hFF00, C_ORR, 0, 12'h000, 0, 0, 1, 4'd12, 32'hFFF0, 32'hFF00));
    vecs.push_back(mk("eor",         2'b00, 2'b00, 0, 0, 32'hF0F0, 32'hFF00, C_EOR, 0, 12'h000, 0, 0, 1, 4'd13, 32'h0FF0, 32'hFF00));
    vecs.push_back(mk("adc_c0",      2'b00, 2'b00, 0, 0, 32'd1, 32'd1, C_ADC, 0, 12'h000, 0, 0, 1, 4'd14, 32'd2, 32'd1));
    vecs.push_back(mk("sbc_c0",      2'b00, 2'b00, 0, 0, 32'd10, 32'd3, C_SBC, 0, 12'h000, 0, 0, 1, 4'd15, 32'd6, 32'd3));
    vecs.push_back(mk("load_addr",   2'b00, 2'b00, 0, 0, 32'h1000, 32'h5, C_ADD, 1, 12'hABC, 1, 0, 1, 4'd3, 32'h1ABC, 32'h5));
    vecs.push_back(mk("store_fwdwb", 2'b00, 2'b10, 0, 32'hDEAD, 32'h2000, 32'h1111, C_ADD, 0, 12'h004, 0, 1, 0, 4'd0, 32'h2004, 32'hDEAD));
    vecs.push_back(mk("rm_fwdmem",   2'b00, 2'b01, 32'h55, 0, 0, 32'h99, C_MOV, 0, 12'h000, 0, 0, 1, 4'd2, 32'h55, 32'h55));
    vecs.push_back(mk("bad_cmd",     2'b00, 2'b00, 0, 0, 32'd5, 32'd5, C_BAD, 0, 12'h000, 0, 0, 1, 4'd1, 32'h0, 32'd5));

    foreach (vecs[i]) begin
      @(negedge clk);
      sel_src1 = vecs[i].sel1; sel_src2 = vecs[i].sel2;
      mem_fwd_val = vecs[i].mfwd; wb_fwd_val = vecs[i].wfwd;
      val_rn_in = vecs[i].rn; val_rm_in = vecs[i].rm;
      exe_cmd_in = vecs[i].cmd; imm_in = vecs[i].imm; shift_op_in = vecs[i].sop;
      mem_r_en_in = vecs[i].mr; mem_w_en_in = vecs[i].mw; wb_en_in = vecs[i].wb;
      dest_in = vecs[i].dest; s_in = 0;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_res"},  ex_alu_res, vecs[i].exp_res);
      check({vecs[i].name, "_st"},   ex_st_val,  vecs[i].exp_st);
      check({vecs[i].name, "_dest"}, {28'h0, ex_dest}, {28'h0, vecs[i].dest});
      check({vecs[i].name, "_ctrl"}, {29'h0, ex_wb_en, ex_mem_r_en, ex_mem_w_en},
            {29'h0, vecs[i].wb, vecs[i].mr, vecs[i].mw});
    end
    check("status_untouched_s0", {28'h0, status}, 32'h0);

    // ---- SUB sets Z,C; following ADC sees C=1 ----
    @(negedge clk);
    wb_en_in = 1; dest_in = 4'd1;
    drive_op(C_SUB, 32'd3, 32'd0, 1, 12'h003, 1);
    @(posedge clk); #1;
    check("sub_eq_res",    ex_alu_res, 32'h0);
    check("sub_eq_status", {28'h0, status}, 32'h6);
    @(negedge clk);
    drive_op(C_ADC, 32'd1, 32'd0, 1, 12'h001, 0);
    @(posedge clk); #1;
    check("adc_c1_res", ex_alu_res, 32'd3);

    // ---- signed overflow ----
    @(negedge clk);
    drive_op(C_ADD, 32'h7FFFFFFF, 32'h1, 0, 12'h000, 1);
    @(posedge clk); #1;
    check("ovf_res",    ex_alu_res, 32'h80000000);
    check("ovf_status", {28'h0, status}, 32'h9);

    // ---- logic op with S: N,Z update, C,V kept (C=0,V=1) ----
    @(negedge clk);
    drive_op(C_AND, 32'h0, 32'hFFFF, 0, 12'h000, 1);
    @(posedge clk); #1;
    check("and_s_status", {28'h0, status}, 32'h5);

    // ---- undefined command with S: no flag change ----
    @(negedge clk);
    drive_op(C_BAD, 32'h8, 32'h8, 0, 12'h000, 1);
    @(posedge clk); #1;
    check("bad_s_status", {28'h0, status}, 32'h5);
    check("bad_s_res",    ex_alu_res, 32'h0);

    // ---- freeze for two cycles, then release ----
    @(negedge clk);
    freeze = 1; wb_en_in = 0; dest_in = 4'd9;
    drive_op(C_ADD, 32'd1, 32'd7, 1, 12'h001, 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("frz_res",    ex_alu_res, 32'h0);
      check("frz_st",     ex_st_val,  32'h8);
      check("frz_dest",   {28'h0, ex_dest}, 32'h1);
      check("frz_wb",     {31'h0, ex_wb_en}, 32'h1);
      check("frz_status", {28'h0, status}, 32'h5);
    end
    @(negedge clk);
    freeze = 0;
    @(posedge clk); #1;
    check("unfrz_res",    ex_alu_res, 32'd2);
    check("unfrz_st",     ex_st_val,  32'd7);
    check("unfrz_dest",   {28'h0, ex_dest}, 32'd9);
    check("unfrz_status", {28'h0, status}, 32'h0);

    // ---- make everything nonzero, then reset while frozen ----
    @(negedge clk);
    wb_en_in = 1; dest_in = 4'd5;
    drive_op(C_ADD, 32'hFFFFFFFF, 32'h2, 0, 12'h000, 1);
    mem_w_en_in = 1;
    shift_op_in = 12'h002;
    @(posedge clk); #1;
    check("pre_rst_res",    ex_alu_res, 32'h1);
    check("pre_rst_status", {28'h0, status}, 32'h2);
    @(negedge clk);
    rst = 1; freeze = 1;
    @(posedge clk); #1;
    check("rstfrz_res",    ex_alu_res, 32'h0);
    check("rstfrz_st",     ex_st_val,  32'h0);
    check("rstfrz_dest",   {28'h0, ex_dest}, 32'h0);
    check("rstfrz_ctrl",   {29'h0, ex_wb_en, ex_mem_r_en, ex_mem_w_en}, 32'h0);
    check("rstfrz_status", {28'h0, status}, 32'h0);
    @(negedge clk);
    rst = 0; freeze = 0;
    idle_inputs();

    // ---- branch target, combinational ----
    @(negedge clk);
    b_in = 1; pc_in = 32'h100; simm24_in = 24'hFFFFFE;
    #1;
    check("br_taken",    {31'h0, branch_taken}, 32'h1);
    check("br_addr_neg", branch_addr, 32'hF8);
    b_in = 0; pc_in = 32'h1000; simm24_in = 24'h000010;
    #1;
    check("br_not_taken", {31'h0, branch_taken}, 32'h0);
    check("br_addr_pos",  branch_addr, 32'h1040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_exe_stage
